obi_avalon_bridge: RTL

- Parametrised OBI-host to Avalon-MM-master bridge with registered responses. It replaces the per-port combinational glue on the core instruction, data and SBA paths.
- Supports up to MaxOutstanding pipelined transactions, using an in-order type queue to route responses.
- Maps the Avalon response code onto OBI err.
- Can synthesise write completions for slaves that have no writeresponsevalid.
- Flags protocol violations in a sticky bit.

---
 rtl/obi_avalon_pkg.sv | 18 +
 rtl/obi_avalon_txn_fifo.sv | 59 +++++
 rtl/obi_avalon_bridge.sv | 126 ++++++++++++
 3 files changed

// File: rtl/obi_avalon_pkg.sv
// Shared types and Avalon response codes for the OBI-to-Avalon bridge.
package obi_avalon_pkg;

   typedef enum logic {
      TXN_READ  = 1'b0,
      TXN_WRITE = 1'b1
   } txn_type_e;

   localparam logic [1:0] AVM_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AVM_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AVM_RESP_DECERR = 2'b11;

   // 2'b01 is reserved on Avalon but is still a non-OKAY completion.
   function automatic logic is_error(input logic [1:0] resp);
      return resp inside {AVM_RESP_SLVERR, AVM_RESP_DECERR, 2'b01};
   endfunction

endpackage

// File: rtl/obi_avalon_txn_fifo.sv
// In-order queue of transaction types used to route Avalon responses back to OBI.
module obi_avalon_txn_fifo
   import obi_avalon_pkg::*;
#(
   parameter  int Depth = 2,
   localparam int CntW  = $clog2(Depth + 1),
   localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  txn_type_e       push_type,
   input  logic            pop,
   output txn_type_e       head,
   output logic            full,
   output logic            empty,
   output logic [CntW-1:0] count
);

   txn_type_e       mem_reg [Depth];
   logic [PtrW-1:0] wr_ptr_reg;
   logic [PtrW-1:0] rd_ptr_reg;
   logic [CntW-1:0] count_reg;

   // Explicit wrap so non-power-of-two depths never index past the last entry.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            mem_reg[wr_ptr_reg] <= push_type;
            wr_ptr_reg          <= ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   assign head  = mem_reg[rd_ptr_reg];
   assign full  = (count_reg == CntW'(Depth));
   assign empty = (count_reg == '0);
   assign count = count_reg;

   a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/obi_avalon_bridge.sv
// OBI host to Avalon-MM master bridge: pipelined commands, in-order registered
// responses, optional synthesised write completions and a sticky protocol flag.
module obi_avalon_bridge
   import obi_avalon_pkg::*;
#(
   parameter  int AddrWidth      = 32,
   parameter  int DataWidth      = 32,
   parameter  int MaxOutstanding = 2,
   parameter  int UseWriteResp   = 1,
   localparam int BeWidth        = DataWidth / 8,
   localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 obi_req_i,
   output logic                 obi_gnt_o,
   input  logic                 obi_we_i,
   input  logic [BeWidth-1:0]   obi_be_i,
   input  logic [AddrWidth-1:0] obi_addr_i,
   input  logic [DataWidth-1:0] obi_wdata_i,
   output logic                 obi_rvalid_o,
   output logic [DataWidth-1:0] obi_rdata_o,
   output logic                 obi_err_o,
   output logic                 avm_read_o,
   output logic                 avm_write_o,
   output logic [AddrWidth-1:0] avm_address_o,
   output logic [BeWidth-1:0]   avm_byteenable_o,
   output logic [DataWidth-1:0] avm_writedata_o,
   input  logic                 avm_waitrequest_i,
   input  logic                 avm_readdatavalid_i,
   input  logic [DataWidth-1:0] avm_readdata_i,
   input  logic [1:0]           avm_response_i,
   input  logic                 avm_writeresponsevalid_i,
   output logic [CntW-1:0]      outstanding_o,
   output logic                 protocol_err_o
);

   logic      space;
   logic      grant;
   logic      pop;
   logic      full;
   logic      empty;
   txn_type_e head;
   logic      wr_resp_valid;
   logic      accept_read;
   logic      accept_write;
   logic      accept_synth;
   logic      violation;

   logic                 rvalid_reg;
   logic [DataWidth-1:0] rdata_reg;
   logic                 err_reg;
   logic                 protocol_err_reg;

   // Space comes from the registered count only, so a same-cycle pop never frees a slot early.
   assign space = !full;
   assign grant = obi_req_i & space & ~avm_waitrequest_i;

   assign obi_gnt_o        = grant;
   assign avm_read_o       = obi_req_i & ~obi_we_i & space;
   assign avm_write_o      = obi_req_i & obi_we_i & space;
   assign avm_address_o    = obi_addr_i;
   assign avm_byteenable_o = obi_be_i;
   assign avm_writedata_o  = obi_wdata_i;

   assign wr_resp_valid = (UseWriteResp != 0) ? avm_writeresponsevalid_i : 1'b0;

   obi_avalon_txn_fifo #(
      .Depth(MaxOutstanding)
   ) u_txn_fifo (
      .clk      (clk_i),
      .rst      (rst_i),
      .push     (grant),
      .push_type(txn_type_e'(obi_we_i)),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (outstanding_o)
   );

   // Responses are matched against the queue head only; anything else is dropped and flagged.
   always_comb begin
      accept_read  = 1'b0;
      accept_write = 1'b0;
      accept_synth = 1'b0;
      violation    = 1'b0;
      if (avm_readdatavalid_i) begin
         if (!empty && head == TXN_READ) accept_read = 1'b1;
         else                            violation   = 1'b1;
      end
      if (wr_resp_valid) begin
         if (!empty && head == TXN_WRITE) accept_write = 1'b1;
         else                             violation    = 1'b1;
      end
      if (UseWriteResp == 0 && !empty && head == TXN_WRITE && !avm_readdatavalid_i) begin
         accept_synth = 1'b1;
      end
   end

   assign pop = accept_read | accept_write | accept_synth;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_reg       <= 1'b0;
         rdata_reg        <= '0;
         err_reg          <= 1'b0;
         protocol_err_reg <= 1'b0;
      end else begin
         rvalid_reg <= pop;
         err_reg    <= (accept_read | accept_write) & is_error(avm_response_i);
         if (accept_read) begin
            rdata_reg <= avm_readdata_i;
         end else if (pop) begin
            rdata_reg <= '0;
         end
         protocol_err_reg <= protocol_err_reg | violation;
      end
   end

   assign obi_rvalid_o   = rvalid_reg;
   assign obi_rdata_o    = rdata_reg;
   assign obi_err_o      = err_reg;
   assign protocol_err_o = protocol_err_reg;

endmodule
